// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin sync, 11-bit frame deframing, make/break/E0 decode into a held-key level.
// Optional build macro PS2_PARITY_CHECK_EN enforces odd parity on received frames.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       key_extended,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       frame_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, SHIFT} frameState_t;
    typedef enum logic [1:0] {BASE, GOT_E0, GOT_F0, GOT_E0F0} prefixState_t;

    frameState_t  frameState, frameNext;
    prefixState_t prefixState, prefixNext;

    logic [1:0]       clkSync, datSync;
    logic             clkHist;
    logic             fallEdge, datBit;
    logic [3:0]       bitCnt;
    logic [7:0]       dataShift;
    logic [CNT_W-1:0] idleCnt;
    logic             frameDone, timeoutHit, parityOk, frameGood, byteAccept;
    logic             keyLoad, keyRelease, extNow, isSpecial;

    // Synchronisers reset to the idle-high bus level so release never fakes an edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clkSync <= 2'b11;
            datSync <= 2'b11;
            clkHist <= 1'b1;
        end else begin
            clkSync <= {clkSync[0], ps2_clk};
            datSync <= {datSync[0], ps2_dat};
            clkHist <= clkSync[1];
        end
    end

    assign fallEdge = clkHist & ~clkSync[1];
    assign datBit   = datSync[1];

`ifdef PS2_PARITY_CHECK_EN
    logic parityBit;
    always_ff @(posedge clock) begin
        if (!resetn)
            parityBit <= 1'b0;
        else if (frameState == SHIFT && fallEdge && bitCnt == 4'd8)
            parityBit <= datBit;
    end
    assign parityOk = ^{dataShift, parityBit};
`else
    assign parityOk = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!resetn)
            frameState <= IDLE;
        else
            frameState <= frameNext;
    end

    // bitCnt 0..7 are data bits, 8 is parity, 9 is the stop bit.
    always_comb begin
        frameNext  = frameState;
        frameDone  = 1'b0;
        timeoutHit = 1'b0;
        case (frameState)
            IDLE: begin
                if (fallEdge && !datBit)
                    frameNext = SHIFT;
            end
            SHIFT: begin
                if (fallEdge) begin
                    if (bitCnt == 4'd9) begin
                        frameNext = IDLE;
                        frameDone = 1'b1;
                    end
                end else if (idleCnt == CNT_LAST) begin
                    frameNext  = IDLE;
                    timeoutHit = 1'b1;
                end
            end
            default: frameNext = IDLE;
        endcase
    end

    assign frameGood  = datBit & parityOk;
    assign byteAccept = frameDone & frameGood;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            bitCnt    <= 4'd0;
            dataShift <= 8'd0;
            idleCnt   <= '0;
        end else begin
            if (frameState == IDLE) begin
                bitCnt <= 4'd0;
            end else if (fallEdge) begin
                if (bitCnt < 4'd8)
                    dataShift <= {datBit, dataShift[7:1]};
                bitCnt <= bitCnt + 4'd1;
            end
            if (frameState == IDLE || fallEdge)
                idleCnt <= '0;
            else if (idleCnt != CNT_LAST)
                idleCnt <= idleCnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            prefixState <= BASE;
        else
            prefixState <= prefixNext;
    end

    always_comb begin
        case (dataShift)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: isSpecial = 1'b1;
            default:                                  isSpecial = 1'b0;
        endcase
    end

    assign extNow = (prefixState == GOT_E0) || (prefixState == GOT_E0F0);

    always_comb begin
        prefixNext = prefixState;
        keyLoad    = 1'b0;
        keyRelease = 1'b0;
        if (timeoutHit) begin
            prefixNext = BASE;
        end else if (byteAccept) begin
            if (dataShift == 8'hE0) begin
                prefixNext = GOT_E0;
            end else if (dataShift == 8'hF0) begin
                if (prefixState == BASE)
                    prefixNext = GOT_F0;
                else if (prefixState == GOT_E0)
                    prefixNext = GOT_E0F0;
            end else if (isSpecial) begin
                prefixNext = BASE;
            end else begin
                prefixNext = BASE;
                if (prefixState == BASE || prefixState == GOT_E0) begin
                    // A typematic repeat of the held key leaves everything as is.
                    if (!(received_data_en && dataShift == received_data && extNow == key_extended))
                        keyLoad = 1'b1;
                end else if (dataShift == received_data && extNow == key_extended) begin
                    keyRelease = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            received_data    <= 8'd0;
            received_data_en <= 1'b0;
            key_extended     <= 1'b0;
            byte_valid       <= 1'b0;
            byte_out         <= 8'd0;
            frame_error      <= 1'b0;
        end else begin
            byte_valid  <= byteAccept;
            frame_error <= timeoutHit | (frameDone & ~frameGood);
            if (byteAccept)
                byte_out <= dataShift;
            if (keyLoad) begin
                received_data    <= dataShift;
                key_extended     <= extNow;
                received_data_en <= 1'b1;
            end else if (keyRelease) begin
                received_data_en <= 1'b0;
            end
        end
    end

endmodule
